// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: loads win, ALU results queue in a FIFO.
// Optional macro RF_WRITEBACK_BYPASS_EN sends an ALU result straight to the outputs when nothing is queued.
module rf_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_byte_off,
  input  logic [31:0] ld_rdata,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic [4:0]  fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  // Handshake: an ALU result transfers on a rising edge where alu_valid && alu_ready;
  // alu_ready depends only on occupancy, loads are never backpressured.
  logic [36:0]   mem_q [DEPTH];
  logic [36:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_reg_q, wr_reg_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic          fifo_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [36:0]   head;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;

  assign alu_ready  = (count_q != DEPTH_C);
  assign fifo_empty = (count_q == 5'd0);
  assign head       = mem_q[rd_ptr_q];

`ifdef RF_WRITEBACK_BYPASS_EN
  assign bypass = alu_valid && alu_ready && fifo_empty && !ld_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = alu_valid && alu_ready && !bypass;
  assign pop  = !ld_valid && !fifo_empty;

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_byte_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_byte_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = ld_rdata;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {alu_rd, alu_data};
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // rd = 0 writes are consumed but never strobed into the register file.
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (ld_valid) begin
      wr_en_d   = (ld_rd != 5'd0);
      wr_reg_d  = ld_rd;
      wr_data_d = ld_fmt;
    end else if (pop) begin
      wr_en_d   = (head[36:32] != 5'd0);
      wr_reg_d  = head[36:32];
      wr_data_d = head[31:0];
    end else if (bypass) begin
      wr_en_d   = (alu_rd != 5'd0);
      wr_reg_d  = alu_rd;
      wr_data_d = alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_reg  = wr_reg_q;
  assign rf_write_data = wr_data_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios plus random traffic against a queue-based model.
module tb_rf_writeback;

  localparam int DEPTH = 4;
`ifdef RF_WRITEBACK_BYPASS_EN
  localparam int ALU_LAT = 1;
`else
  localparam int ALU_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic [31:0] ld_rdata;
  logic        rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [4:0]  fifo_count;

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_byte_off(ld_byte_off),
    .ld_rdata(ld_rdata),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load formatting from the ISA rules: shift the wanted lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          hsel;
    b    = 8'(w >> (8 * int'(off)));
    hsel = int'(off) / 2;
    h    = 16'(w >> (16 * hsel));
    if (f3 == 3'b000) return 32'($signed(b));
    if (f3 == 3'b100) return 32'(b);
    if (f3 == 3'b001) return 32'($signed(h));
    if (f3 == 3'b101) return 32'(h);
    return w;
  endfunction

  task automatic set_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_byte_off = '0; ld_rdata = '0;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] w);
    ld_valid = v; ld_rd = rd; ld_funct3 = f3; ld_byte_off = off; ld_rdata = w;
  endtask

  // One clock cycle: check ready, predict the write, clock, then check outputs.
  task automatic step();
    logic        exp_ready, accept, byp, exp_en;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [36:0] head;
    #1;
    exp_ready = (exp_q.size() != DEPTH);
    check("alu_ready", 32'(alu_ready), 32'(exp_ready));
    accept   = alu_valid && exp_ready;
    byp      = 1'b0;
    exp_en   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    if (ld_valid) begin
      exp_en   = (ld_rd != 0);
      exp_reg  = ld_rd;
      exp_data = ref_load(ld_funct3, ld_byte_off, ld_rdata);
    end else if (exp_q.size() > 0) begin
      head     = exp_q.pop_front();
      exp_en   = (head[36:32] != 0);
      exp_reg  = head[36:32];
      exp_data = head[31:0];
    end
`ifdef RF_WRITEBACK_BYPASS_EN
    else if (accept) begin
      byp      = 1'b1;
      exp_en   = (alu_rd != 0);
      exp_reg  = alu_rd;
      exp_data = alu_data;
    end
`endif
    if (accept && !byp) exp_q.push_back({alu_rd, alu_data});
    @(posedge clk);
    #1;
    check("write_en", 32'(rf_write_en), 32'(exp_en));
    if (exp_en) begin
      check("write_reg", 32'(rf_write_reg), 32'(exp_reg));
      check("write_data", rf_write_data, exp_data);
    end
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    int         lat;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    // Reset state
    rst = 1'b0;
    set_idle();
    #12;
    check("rst_en", 32'(rf_write_en), 32'd0);
    check("rst_reg", 32'(rf_write_reg), 32'd0);
    check("rst_data", rf_write_data, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single ALU result latency
    drive_alu(1'b1, 5'd5, 32'h0000_1234);
    step();
    set_idle();
    lat = 1;
    if (rf_write_en !== 1'b1) begin
      step();
      lat = 2;
    end
    check("alu_latency", 32'(lat), 32'(ALU_LAT));
    check("alu_lat_reg", 32'(rf_write_reg), 32'd5);
    check("alu_lat_data", rf_write_data, 32'h0000_1234);
    step();

    // Load formatting corner values
    drive_ld(1'b1, 5'd7, 3'b000, 2'd3, 32'h80FF_7F01); step();
    check("lb_off3", rf_write_data, 32'hFFFF_FF80);
    drive_ld(1'b1, 5'd7, 3'b100, 2'd3, 32'h80FF_7F01); step();
    check("lbu_off3", rf_write_data, 32'h0000_0080);
    drive_ld(1'b1, 5'd7, 3'b001, 2'd2, 32'h80FF_7F01); step();
    check("lh_off2", rf_write_data, 32'hFFFF_80FF);
    drive_ld(1'b1, 5'd7, 3'b101, 2'd0, 32'h80FF_7F01); step();
    check("lhu_off0", rf_write_data, 32'h0000_7F01);
    drive_ld(1'b1, 5'd7, 3'b011, 2'd1, 32'h80FF_7F01); step();
    check("ld_other", rf_write_data, 32'h80FF_7F01);
    set_idle();
    step();

    // Loads hold off the FIFO while ALU pushes until full
    for (int i = 0; i < 6; i++) begin
      drive_alu(1'b1, 5'(10 + i), $urandom);
      drive_ld(1'b1, 5'(1 + i), 3'b010, 2'd0, $urandom);
      step();
    end
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    set_idle();
    for (int i = 0; i < 5; i++) step();

    // rd = 0 from both sources
    drive_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    drive_ld(1'b1, 5'd0, 3'b010, 2'd0, 32'h1111_2222);
    step();
    set_idle();
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 5'(20 + i), $urandom);
      drive_ld(1'b1, 5'd9, 3'b010, 2'd0, 32'hA5A5_0000 | 32'(i + 1));
      step();
    end
    set_idle();
    #3;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_en", 32'(rf_write_en), 32'd0);
    check("arst_reg", 32'(rf_write_reg), 32'd0);
    check("arst_data", rf_write_data, 32'd0);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_ready", 32'(alu_ready), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Fill and drain three times across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        drive_alu(1'b1, 5'($urandom_range(1, 31)), $urandom);
        drive_ld(1'b1, 5'd0, 3'b010, 2'd0, $urandom);
        step();
      end
      set_idle();
      for (int i = 0; i < DEPTH + 1; i++) step();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_alu(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom);
      drive_ld(1'($urandom_range(0, 99) < 35), 5'($urandom_range(0, 31)),
               f3_tab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), $urandom);
      step();
    end
    set_idle();
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
